multiciclo_control_hs: RTL and testbench

Second-generation multicycle control FSM for the RISC-V core: drives the shared memory port, IR/PC/CurrentPC write enables, register-file write, ALU input muxes and ALUOp from the IR opcode. It extends the previous controller in three ways:
- a `mem_ready` handshake with parametrised timeout
- full RV32I instruction-class coverage (OP-IMM, JALR, AUIPC added)
- an optional illegal-instruction trap

It sits between the IR and the multicycle datapath.

---
 rtl/multiciclo_pkg.sv | 70 +++++++
 rtl/multiciclo_wait_timer.sv | 40 ++++
 rtl/multiciclo_control_hs.sv | 215 +++++++++++++++++++++
 tb/tb_multiciclo_control_hs.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/multiciclo_pkg.sv
// Shared constants for the multicycle RV32I controller: state encodings,
// opcodes, datapath mux selects and ALUOp codes.
package multiciclo_pkg;

    // State encodings (4 bits; wider state registers zero-extend)
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_ADDR      = 4'd2;
    localparam logic [3:0] S_LOAD      = 4'd3;
    localparam logic [3:0] S_LOAD_SAVE = 4'd4;
    localparam logic [3:0] S_STORE     = 4'd5;
    localparam logic [3:0] S_TIPOR     = 4'd6;
    localparam logic [3:0] S_TIPOI     = 4'd7;
    localparam logic [3:0] S_ALU_SAVE  = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JAL       = 4'd10;
    localparam logic [3:0] S_JALR      = 4'd11;
    localparam logic [3:0] S_LUI       = 4'd12;
    localparam logic [3:0] S_HALT      = 4'd13;
    localparam logic [3:0] S_TRAP      = 4'd14;

    // RV32I major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Memory address mux
    localparam logic ADDRESS_PC      = 1'b0;
    localparam logic ADDRESS_ALU_REG = 1'b1;

    // Register-file write data mux
    localparam logic [1:0] REGISTER_ALU    = 2'd0;
    localparam logic [1:0] REGISTER_MEMORY = 2'd1;
    localparam logic [1:0] REGISTER_PC4    = 2'd2;
    localparam logic [1:0] REGISTER_IMM    = 2'd3;

    // ALU operand muxes
    localparam logic [1:0] INPUT_A_PC         = 2'd0;
    localparam logic [1:0] INPUT_A_CURRENT_PC = 2'd1;
    localparam logic [1:0] INPUT_A_REGISTER   = 2'd2;
    localparam logic [1:0] INPUT_B_REGISTER   = 2'd0;
    localparam logic [1:0] INPUT_B_FOUR       = 2'd1;
    localparam logic [1:0] INPUT_B_IMMEDIATE  = 2'd2;

    // PC source mux
    localparam logic [1:0] PC_ALU     = 2'd0;
    localparam logic [1:0] PC_ALU_REG = 2'd1;
    localparam logic [1:0] PC_TRAP    = 2'd2;

    // ALUOp codes
    localparam logic [1:0] ALUOP_ADD    = 2'd0;
    localparam logic [1:0] ALUOP_SUB    = 2'd1;
    localparam logic [1:0] ALUOP_RFUNCT = 2'd2;
    localparam logic [1:0] ALUOP_IFUNCT = 2'd3;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // States that own the memory port and may stall on mem_ready
    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_LOAD) || (s == S_STORE);
    endfunction

endpackage

// File: rtl/multiciclo_wait_timer.sv
// Memory wait counter: counts consecutive not-ready cycles of one access.
// expired is high when the count reaches MEM_TIMEOUT (never when it is 0).
module multiciclo_wait_timer #(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    // A zero-timeout build still keeps a 1-bit counter so the width is legal
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear has priority; increment saturates at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (inc && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    generate
        if (MEM_TIMEOUT > 0) begin : g_to
            assign expired = (cnt_q == CNT_W'(MEM_TIMEOUT));
        end else begin : g_no_to
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multiciclo_control_hs.sv
// Multicycle RV32I control FSM with mem_ready handshake and access timeout.
// Optional illegal-instruction trap enabled by defining MULTICICLO_TRAP_EN.
module multiciclo_control_hs
    import multiciclo_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0,
    parameter int STATE_W     = 4,
    parameter int ALUOP_W     = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    output logic               MemoryAddressOrigin,
    output logic               WriteMemory,
    output logic               ReadMemory,
    output logic               WriteInstructionRegister,
    output logic               WriteCurrentPC,
    output logic               WritePC,
    output logic               WriteRegister,
    output logic [1:0]         RegisterInputOrigin,
    output logic [1:0]         ALUInputAOrigin,
    output logic [1:0]         ALUInputBOrigin,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCOrigin,
    output logic               Branch,
    output logic               IllegalInstr,
    output logic               MemError,
    output logic [STATE_W-1:0] oState,
    output logic [STATE_W-1:0] oNextState
);
    logic [STATE_W-1:0] state_q, state_d;
    logic               mem_error_q, mem_error_d;
    logic [3:0]         st, nxt;
    logic               expired, mem_st;

    // Encodings fit in 4 bits; any extra state bits stay zero
    assign st     = state_q[3:0];
    assign mem_st = is_mem_state(st);

    multiciclo_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!mem_st || mem_ready),
        .inc     (mem_st && !mem_ready),
        .expired (expired)
    );

    // Next-state and sticky timeout flag; mem_ready beats expiry
    always_comb begin
        nxt         = st;
        mem_error_d = mem_error_q;
        case (st)
            S_FETCH, S_LOAD, S_STORE: begin
                if (mem_ready) begin
                    if (st == S_FETCH)     nxt = S_DECODE;
                    else if (st == S_LOAD) nxt = S_LOAD_SAVE;
                    else                   nxt = S_FETCH;
                end else if (expired) begin
                    nxt         = S_HALT;
                    mem_error_d = TRUE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = S_ADDR;
                    OP_R:              nxt = S_TIPOR;
                    OP_IMM:            nxt = S_TIPOI;
                    OP_BRANCH:         nxt = S_BRANCH;
                    OP_JAL:            nxt = S_JAL;
                    OP_JALR:           nxt = S_JALR;
                    OP_LUI:            nxt = S_LUI;
                    OP_AUIPC:          nxt = S_ALU_SAVE;
`ifdef MULTICICLO_TRAP_EN
                    default:           nxt = S_TRAP;
`else
                    default:           nxt = S_FETCH;
`endif
                endcase
            end
            S_ADDR:            nxt = (opcode == OP_STORE) ? S_STORE : S_LOAD;
            S_TIPOR, S_TIPOI:  nxt = S_ALU_SAVE;
            S_HALT:            nxt = S_HALT;
            default:           nxt = S_FETCH;
        endcase
        state_d = STATE_W'(nxt);
    end

    // State and error flag registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= STATE_W'(S_FETCH);
            mem_error_q <= FALSE;
        end else begin
            state_q     <= state_d;
            mem_error_q <= mem_error_d;
        end
    end

    logic       rd_c, wr_c, ir_c, cpc_c, wpc_c, wreg_c, br_c, addr_c;
    logic [1:0] regin_c, a_c, b_c, aluop_c, pco_c;
`ifdef MULTICICLO_TRAP_EN
    logic       ill_c;
`endif

    // Moore decode of datapath controls; FETCH writes wait for mem_ready
    always_comb begin
        rd_c = FALSE; wr_c = FALSE; ir_c = FALSE; cpc_c = FALSE;
        wpc_c = FALSE; wreg_c = FALSE; br_c = FALSE;
        addr_c  = ADDRESS_PC;
        regin_c = REGISTER_ALU;
        a_c     = INPUT_A_PC;
        b_c     = INPUT_B_FOUR;
        aluop_c = ALUOP_ADD;
        pco_c   = PC_ALU;
`ifdef MULTICICLO_TRAP_EN
        ill_c   = FALSE;
`endif
        case (st)
            S_FETCH: begin
                rd_c  = TRUE;
                ir_c  = mem_ready;
                cpc_c = mem_ready;
                wpc_c = mem_ready;
            end
            S_DECODE: begin
                a_c = INPUT_A_CURRENT_PC;
                b_c = INPUT_B_IMMEDIATE;
            end
            S_ADDR: begin
                a_c = INPUT_A_REGISTER;
                b_c = INPUT_B_IMMEDIATE;
            end
            S_LOAD: begin
                addr_c = ADDRESS_ALU_REG;
                rd_c   = TRUE;
            end
            S_LOAD_SAVE: begin
                regin_c = REGISTER_MEMORY;
                wreg_c  = TRUE;
            end
            S_STORE: begin
                addr_c = ADDRESS_ALU_REG;
                wr_c   = TRUE;
            end
            S_TIPOR: begin
                a_c     = INPUT_A_REGISTER;
                b_c     = INPUT_B_REGISTER;
                aluop_c = ALUOP_RFUNCT;
            end
            S_TIPOI: begin
                a_c     = INPUT_A_REGISTER;
                b_c     = INPUT_B_IMMEDIATE;
                aluop_c = ALUOP_IFUNCT;
            end
            S_ALU_SAVE: wreg_c = TRUE;
            S_BRANCH: begin
                a_c     = INPUT_A_REGISTER;
                b_c     = INPUT_B_REGISTER;
                aluop_c = ALUOP_SUB;
                br_c    = TRUE;
                pco_c   = PC_ALU_REG;
            end
            S_JAL: begin
                regin_c = REGISTER_PC4;
                wreg_c  = TRUE;
                pco_c   = PC_ALU_REG;
                wpc_c   = TRUE;
            end
            S_JALR: begin
                a_c     = INPUT_A_REGISTER;
                b_c     = INPUT_B_IMMEDIATE;
                regin_c = REGISTER_PC4;
                wreg_c  = TRUE;
                wpc_c   = TRUE;
            end
            S_LUI: begin
                regin_c = REGISTER_IMM;
                wreg_c  = TRUE;
            end
`ifdef MULTICICLO_TRAP_EN
            S_TRAP: begin
                ill_c = TRUE;
                pco_c = PC_TRAP;
                wpc_c = TRUE;
            end
`endif
            default: ;
        endcase
    end

    // Strobes are forced low while reset is asserted
    assign ReadMemory               = reset_n & rd_c;
    assign WriteMemory              = reset_n & wr_c;
    assign WriteInstructionRegister = reset_n & ir_c;
    assign WriteCurrentPC           = reset_n & cpc_c;
    assign WritePC                  = reset_n & wpc_c;
    assign WriteRegister            = reset_n & wreg_c;
    assign Branch                   = reset_n & br_c;
`ifdef MULTICICLO_TRAP_EN
    assign IllegalInstr             = reset_n & ill_c;
`else
    assign IllegalInstr             = 1'b0;
`endif
    assign MemoryAddressOrigin = addr_c;
    assign RegisterInputOrigin = regin_c;
    assign ALUInputAOrigin     = a_c;
    assign ALUInputBOrigin     = b_c;
    assign ALUOp               = ALUOP_W'(aluop_c);
    assign PCOrigin            = pco_c;
    assign MemError            = mem_error_q;
    assign oState              = state_q;
    assign oNextState          = state_d;

endmodule

// File: tb/tb_multiciclo_control_hs.sv
// Scoreboard bench for multiciclo_control_hs (MEM_TIMEOUT = 4).
// The driver pushes hand-computed per-cycle expectations; the monitor
// pops one per cycle on the falling edge and compares.
module tb_multiciclo_control_hs;
    import multiciclo_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       MemoryAddressOrigin, WriteMemory, ReadMemory;
    logic       WriteInstructionRegister, WriteCurrentPC, WritePC, WriteRegister;
    logic [1:0] RegisterInputOrigin, ALUInputAOrigin, ALUInputBOrigin, ALUOp, PCOrigin;
    logic       Branch, IllegalInstr, MemError;
    logic [3:0] oState, oNextState;

    multiciclo_control_hs #(.MEM_TIMEOUT(4), .STATE_W(4), .ALUOP_W(2)) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .MemoryAddressOrigin(MemoryAddressOrigin), .WriteMemory(WriteMemory),
        .ReadMemory(ReadMemory), .WriteInstructionRegister(WriteInstructionRegister),
        .WriteCurrentPC(WriteCurrentPC), .WritePC(WritePC), .WriteRegister(WriteRegister),
        .RegisterInputOrigin(RegisterInputOrigin), .ALUInputAOrigin(ALUInputAOrigin),
        .ALUInputBOrigin(ALUInputBOrigin), .ALUOp(ALUOp), .PCOrigin(PCOrigin),
        .Branch(Branch), .IllegalInstr(IllegalInstr), .MemError(MemError),
        .oState(oState), .oNextState(oNextState)
    );

    always #5 clock = ~clock;

    // Strobe vector: {rd, wr, ir, cpc, wpc, wreg, br, ill, merr, addr}
    localparam logic [9:0] Z   = 10'b0000000000;
    localparam logic [9:0] F1  = 10'b1011100000;
    localparam logic [9:0] F0  = 10'b1000000000;
    localparam logic [9:0] WRG = 10'b0000010000;
    localparam logic [9:0] LD  = 10'b1000000001;
    localparam logic [9:0] ST  = 10'b0100000001;
    localparam logic [9:0] JRS = 10'b0000110000;
    localparam logic [9:0] TPS = 10'b0000100100;
    localparam logic [9:0] HE  = 10'b0000000010;
    // Mux vector: {regin, a, b, aluop, pco}
    localparam logic [9:0] DEF = 10'b00_00_01_00_00;
    localparam logic [9:0] DEC = 10'b00_01_10_00_00;
    localparam logic [9:0] TR  = 10'b00_10_00_10_00;
    localparam logic [9:0] ADR = 10'b00_10_10_00_00;
    localparam logic [9:0] LSV = 10'b01_00_01_00_00;
    localparam logic [9:0] JR  = 10'b10_10_10_00_00;
    localparam logic [9:0] TRP = 10'b00_00_01_00_10;

    typedef struct {
        logic [3:0] st;
        logic [9:0] sb;
        logic [9:0] mx;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    task automatic chk(input string nm, input int c, input logic [9:0] act, input logic [9:0] ex);
        tests++;
        if (act !== ex) begin
            fails++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, c, act, ex);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state", e.cyc, {6'd0, oState}, {6'd0, e.st});
                chk("strobes", e.cyc, {ReadMemory, WriteMemory, WriteInstructionRegister,
                    WriteCurrentPC, WritePC, WriteRegister, Branch, IllegalInstr,
                    MemError, MemoryAddressOrigin}, e.sb);
                chk("muxes", e.cyc, {RegisterInputOrigin, ALUInputAOrigin, ALUInputBOrigin,
                    ALUOp, PCOrigin}, e.mx);
            end
        end
    end

    // Drive one cycle of inputs just after the edge and queue its expectation
    task automatic step(input logic rn, input logic r, input logic [6:0] op,
                        input logic [3:0] st, input logic [9:0] sb, input logic [9:0] mx);
        exp_t e;
        @(posedge clock);
        #1;
        reset_n   = rn;
        mem_ready = r;
        opcode    = op;
        cyc++;
        e.st = st; e.sb = sb; e.mx = mx; e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    initial begin
        // Reset: strobes forced low even with mem_ready high
        step(0, 1, OP_R, S_FETCH, Z, DEF);
        step(0, 1, OP_R, S_FETCH, Z, DEF);
        // ADD: FETCH, DECODE, TIPOR, ALU_SAVE
        step(1, 1, OP_R, S_FETCH,    F1,  DEF);
        step(1, 1, OP_R, S_DECODE,   Z,   DEC);
        step(1, 1, OP_R, S_TIPOR,    Z,   TR);
        step(1, 1, OP_R, S_ALU_SAVE, WRG, DEF);
        // LOAD with 3 fetch stalls and 2 load stalls: 10 cycles
        step(1, 0, OP_LOAD, S_FETCH,     F0,  DEF);
        step(1, 0, OP_LOAD, S_FETCH,     F0,  DEF);
        step(1, 0, OP_LOAD, S_FETCH,     F0,  DEF);
        step(1, 1, OP_LOAD, S_FETCH,     F1,  DEF);
        step(1, 1, OP_LOAD, S_DECODE,    Z,   DEC);
        step(1, 1, OP_LOAD, S_ADDR,      Z,   ADR);
        step(1, 0, OP_LOAD, S_LOAD,      LD,  DEF);
        step(1, 0, OP_LOAD, S_LOAD,      LD,  DEF);
        step(1, 1, OP_LOAD, S_LOAD,      LD,  DEF);
        step(1, 1, OP_LOAD, S_LOAD_SAVE, WRG, LSV);
        // JALR
        step(1, 1, OP_JALR, S_FETCH,  F1,  DEF);
        step(1, 1, OP_JALR, S_DECODE, Z,   DEC);
        step(1, 1, OP_JALR, S_JALR,   JRS, JR);
        // Illegal opcode
        step(1, 1, 7'b1111111, S_FETCH,  F1, DEF);
        step(1, 1, 7'b1111111, S_DECODE, Z,  DEC);
`ifdef MULTICICLO_TRAP_EN
        step(1, 1, 7'b1111111, S_TRAP,   TPS, TRP);
`endif
        // STORE: mem_ready arrives exactly at expiry, so no error
        step(1, 1, OP_STORE, S_FETCH,  F1, DEF);
        step(1, 1, OP_STORE, S_DECODE, Z,  DEC);
        step(1, 1, OP_STORE, S_ADDR,   Z,  ADR);
        step(1, 0, OP_STORE, S_STORE,  ST, DEF);
        step(1, 0, OP_STORE, S_STORE,  ST, DEF);
        step(1, 0, OP_STORE, S_STORE,  ST, DEF);
        step(1, 0, OP_STORE, S_STORE,  ST, DEF);
        step(1, 1, OP_STORE, S_STORE,  ST, DEF);
        // LOAD interrupted by reset during the load wait
        step(1, 1, OP_LOAD, S_FETCH,  F1, DEF);
        step(1, 1, OP_LOAD, S_DECODE, Z,  DEC);
        step(1, 1, OP_LOAD, S_ADDR,   Z,  ADR);
        step(1, 0, OP_LOAD, S_LOAD,   LD, DEF);
        step(1, 0, OP_LOAD, S_LOAD,   LD, DEF);
        step(0, 0, OP_LOAD, S_FETCH,  Z,  DEF);
        // Counter restarted: four stalls then ready at the limit, no halt
        step(1, 0, OP_LOAD, S_FETCH,     F0,  DEF);
        step(1, 0, OP_LOAD, S_FETCH,     F0,  DEF);
        step(1, 0, OP_LOAD, S_FETCH,     F0,  DEF);
        step(1, 0, OP_LOAD, S_FETCH,     F0,  DEF);
        step(1, 1, OP_LOAD, S_FETCH,     F1,  DEF);
        step(1, 1, OP_LOAD, S_DECODE,    Z,   DEC);
        step(1, 1, OP_LOAD, S_ADDR,      Z,   ADR);
        step(1, 1, OP_LOAD, S_LOAD,      LD,  DEF);
        step(1, 1, OP_LOAD, S_LOAD_SAVE, WRG, LSV);
        // STORE with mem_ready stuck low: HALT with sticky MemError
        step(1, 1, OP_STORE, S_FETCH,  F1, DEF);
        step(1, 1, OP_STORE, S_DECODE, Z,  DEC);
        step(1, 1, OP_STORE, S_ADDR,   Z,  ADR);
        step(1, 0, OP_STORE, S_STORE,  ST, DEF);
        step(1, 0, OP_STORE, S_STORE,  ST, DEF);
        step(1, 0, OP_STORE, S_STORE,  ST, DEF);
        step(1, 0, OP_STORE, S_STORE,  ST, DEF);
        step(1, 0, OP_STORE, S_STORE,  ST, DEF);
        step(1, 0, OP_STORE, S_HALT,   HE, DEF);
        step(1, 1, OP_STORE, S_HALT,   HE, DEF);
        step(1, 1, OP_STORE, S_HALT,   HE, DEF);
        // Reset pulse clears MemError and restarts fetch
        step(0, 1, OP_LUI, S_FETCH,  Z,  DEF);
        step(1, 1, OP_LUI, S_FETCH,  F1, DEF);
        step(1, 1, OP_LUI, S_DECODE, Z,  DEC);
        step(1, 1, OP_LUI, S_LUI,    WRG, 10'b11_00_01_00_00);
        @(negedge clock);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
